heartbeat_monitor: RTL and testbench
====================================

HEARTBEAT_MONITOR -- requirements
Module: heartbeat_monitor

Interface
REQ-001 SHALL have parameter N, default 8: expected heartbeat period P = 2^N clk cycles.
REQ-002 SHALL have parameter TOL, default 2: allowed period deviation in cycles; legal 0..2^(N-1)-1.
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive good intervals needed to lock; legal 1..15.
REQ-004 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port hb_in  input  1  heartbeat pulse from the generator; may be asynchronous to clk.
REQ-007 SHALL have port err_clr  input  1  synchronous clear of both error counters.
REQ-008 SHALL have port alive  output  1  high while the monitor is in LOCKED.
REQ-009 SHALL have port miss  output  1  one-cycle pulse on a missed heartbeat.
REQ-010 SHALL have port early  output  1  one-cycle pulse on an early heartbeat.
REQ-011 SHALL have port miss_cnt  output  8  saturating count of miss events.
REQ-012 SHALL have port early_cnt  output  8  saturating count of early events.
REQ-013 SHALL have port last_interval  output  N+2  last measured edge-to-edge interval.
REQ-014 SHALL have port state  output  2  FSM state: IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3.

Function
REQ-015 SHALL pass hb_in through a 2-flop synchronizer, then a rising-edge detector; hb_in high at clk edge k yields internal edge in cycle k+2, with registered effects visible after edge k+3.
REQ-016 SHALL count a pulse held high for multiple cycles as one edge.
REQ-017 SHALL keep interval counter I (N+2 bits): on edge, capture I into last_interval and load I=1; otherwise I = min(I+1, HI+1), where LO = P-TOL and HI = P+TOL.
REQ-018 SHALL classify an edge as good when LO <= I <= HI, early when I < LO, and restart-only when I = HI+1.
REQ-019 SHALL raise miss for exactly one cycle when I steps from HI to HI+1 in ACQUIRE or LOCKED; it SHALL NOT fire again until the next edge.
REQ-020 SHALL implement IDLE: on the first edge go to ACQUIRE with good_cnt=0; no classification and no miss are performed in IDLE.
REQ-021 SHALL implement ACQUIRE: good edge increments good_cnt, reaching LOCK_CNT goes to LOCKED; early edge pulses early, clears good_cnt and stays; miss goes to IDLE.
REQ-022 SHALL implement LOCKED: good edge stays; early edge pulses early and goes to ACQUIRE with good_cnt=0; miss goes to LOST.
REQ-023 SHALL implement LOST: the next edge goes to ACQUIRE with good_cnt=0, with no early or miss pulse.
REQ-024 SHALL register alive as (next state == LOCKED), so it changes on the same edge as state.
REQ-025 SHALL saturate miss_cnt and early_cnt at 255.
REQ-026 SHALL give err_clr priority over a simultaneous increment: the counter becomes 0 and that event is lost.
REQ-027 SHALL leave the FSM, I and last_interval unaffected by err_clr.

Reset
REQ-028 SHALL, while nreset is low, force: synchronizer and edge flops 0, I=0, good_cnt=0, state=IDLE, alive=0, miss=0, early=0, miss_cnt=0, early_cnt=0, last_interval=0.
REQ-029 SHALL, on reset mid-operation, discard all history; the first edge after release is treated as the IDLE first edge.
REQ-030 SHALL keep the I counter frozen in IDLE, so no miss can fire before the first heartbeat.

Structure
REQ-031 SHALL place the FSM state encoding and state width constant in the shared package heartbeat_pkg.
REQ-032 SHALL place the synchronizer plus edge detector in sub-module hb_sync_edge (in: clk, nreset, d; out: rise).
REQ-033 SHALL derive LO, HI and the counter widths from parameters, with no hard-coded values.

Verification (N=8, TOL=2, LOCK_CNT=4; P=256, LO=254, HI=258)
REQ-034 SHALL cover: 6 pulses 256 cycles apart -> state goes IDLE, ACQUIRE, then LOCKED with alive=1 after the 5th edge; last_interval=256; no miss or early pulse.
REQ-035 SHALL cover: locked, then pulses stop -> exactly one miss pulse 259 cycles after the last edge; state=LOST; alive=0; miss_cnt=1.
REQ-036 SHALL cover: locked, next pulse at interval 250 -> one early pulse; early_cnt=1; state=ACQUIRE; 4 more good intervals re-lock.
REQ-037 SHALL cover: intervals of 254 and 258 -> both classified good; 253 -> early; a pulse at 259 after a miss -> restart only, no extra pulse.
REQ-038 SHALL cover: err_clr in the same cycle as a miss -> miss pulses, miss_cnt=0; 300 injected misses with no clear -> miss_cnt=255.
REQ-039 SHALL cover: nreset asserted mid-LOCKED -> all outputs 0 and state=IDLE immediately; after release, no miss fires without hb_in activity.

Source files
------------

// File: rtl/heartbeat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : heartbeat_pkg                                              |
// | Brief   : Shared FSM encoding and helpers for the heartbeat monitor. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package heartbeat_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } hb_state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hb_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hb_sync_edge                                               |
// | Brief   : Two-flop synchronizer followed by a registered rising-edge |
// |           detector; a long high pulse yields a single rise.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hb_sync_edge (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchronize d, remember the previous sample, register the 0->1 transition.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/heartbeat_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : heartbeat_monitor                                          |
// | Brief   : Measures heartbeat edge-to-edge intervals, locks after     |
// |           LOCK_CNT good periods, flags early/missed beats and keeps  |
// |           saturating error counters.                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int N        = 8,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               hb_in,
  input  logic               err_clr,
  output logic               alive,
  output logic               miss,
  output logic               early,
  output logic [7:0]         miss_cnt,
  output logic [7:0]         early_cnt,
  output logic [N+1:0]       last_interval,
  output logic [STATE_W-1:0] state
);

  localparam int CW = N + 2;
  localparam int GW = 4;

  localparam logic [CW-1:0] c_one       = CW'(1);
  localparam logic [CW-1:0] c_period    = c_one << N;
  localparam logic [CW-1:0] c_lo        = c_period - CW'(TOL);
  localparam logic [CW-1:0] c_hi        = c_period + CW'(TOL);
  localparam logic [CW-1:0] c_hi1       = c_hi + c_one;
  localparam logic [GW-1:0] c_lock_last = GW'(LOCK_CNT - 1);

  hb_state_t     state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [CW-1:0] ivl_q, ivl_d;
  logic [CW-1:0] last_q, last_d;
  logic          alive_q;
  logic          miss_q, miss_d;
  logic          early_q, early_d;
  logic [7:0]    miss_cnt_q;
  logic [7:0]    early_cnt_q;

  logic w_rise;
  logic w_good;
  logic w_early;
  logic w_miss;

  hb_sync_edge u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (hb_in),
    .rise   (w_rise)
  );

  assign w_good  = (ivl_q >= c_lo) && (ivl_q <= c_hi);
  assign w_early = (ivl_q < c_lo);
  // The miss event is the single step HI -> HI+1; an edge on that cycle wins.
  assign w_miss  = !w_rise && (ivl_q == c_hi);

  // Next-state logic: interval counter, edge classification and FSM transitions.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    ivl_d      = ivl_q;
    last_d     = last_q;
    early_d    = 1'b0;
    miss_d     = 1'b0;

    // Counter is frozen in IDLE and saturates at HI+1 elsewhere.
    if (w_rise) begin
      last_d = ivl_q;
      ivl_d  = c_one;
    end else if ((state_q != ST_IDLE) && (ivl_q < c_hi1)) begin
      ivl_d = ivl_q + c_one;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_rise) begin
          if (w_good) begin
            if (good_cnt_q == c_lock_last) state_d = ST_LOCKED;
            else                           good_cnt_d = good_cnt_q + GW'(1);
          end else begin
            good_cnt_d = '0;
            early_d    = w_early;
          end
        end else if (w_miss) begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
          miss_d     = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_rise) begin
          if (!w_good) begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = '0;
            early_d    = w_early;
          end
        end else if (w_miss) begin
          state_d = ST_LOST;
          miss_d  = 1'b1;
        end
      end
      ST_LOST: begin
        if (w_rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, interval tracking and registered status outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      good_cnt_q <= '0;
      ivl_q      <= '0;
      last_q     <= '0;
      alive_q    <= 1'b0;
      miss_q     <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      ivl_q      <= ivl_d;
      last_q     <= last_d;
      alive_q    <= (state_d == ST_LOCKED);
      miss_q     <= miss_d;
      early_q    <= early_d;
    end
  end

  // Saturating error counters; a clear drops any coincident event.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      miss_cnt_q  <= 8'd0;
      early_cnt_q <= 8'd0;
    end else if (err_clr) begin
      miss_cnt_q  <= 8'd0;
      early_cnt_q <= 8'd0;
    end else begin
      if (miss_d)  miss_cnt_q  <= sat_inc8(miss_cnt_q);
      if (early_d) early_cnt_q <= sat_inc8(early_cnt_q);
    end
  end

  assign alive         = alive_q;
  assign miss          = miss_q;
  assign early         = early_q;
  assign miss_cnt      = miss_cnt_q;
  assign early_cnt     = early_cnt_q;
  assign last_interval = last_q;
  assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_heartbeat_monitor                                       |
// | Brief   : Self-checking bench; expected miss/early pulses are queued |
// |           with their cycle and popped as the DUT emits them.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_heartbeat_monitor;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       hb_in = 1'b0;
  logic       err_clr = 1'b0;
  logic       alive, miss, early;
  logic [7:0] miss_cnt, early_cnt;
  logic [9:0] last_interval;
  logic [1:0] st;

  // Small instance used only to reach counter saturation quickly.
  logic       hb_s = 1'b0;
  logic       clr_s = 1'b0;
  logic       alive_s, miss_s, early_s;
  logic [7:0] miss_cnt_s, early_cnt_s;
  logic [5:0] last_s;
  logic [1:0] st_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_drive = 0;
  int s_seen = 0;

  typedef struct { bit is_miss; int cyc; } ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;

  heartbeat_monitor #(.N(8), .TOL(2), .LOCK_CNT(4)) dut (
    .clk(clk), .nreset(nreset), .hb_in(hb_in), .err_clr(err_clr),
    .alive(alive), .miss(miss), .early(early),
    .miss_cnt(miss_cnt), .early_cnt(early_cnt),
    .last_interval(last_interval), .state(st)
  );

  heartbeat_monitor #(.N(4), .TOL(1), .LOCK_CNT(1)) dut_s (
    .clk(clk), .nreset(nreset), .hb_in(hb_s), .err_clr(clr_s),
    .alive(alive_s), .miss(miss_s), .early(early_s),
    .miss_cnt(miss_cnt_s), .early_cnt(early_cnt_s),
    .last_interval(last_s), .state(st_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every miss/early pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (nreset && (miss === 1'b1 || early === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: miss=%0b early=%0b at cycle %0d, required no pulse", miss, early, cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        if (miss !== mon_ev.is_miss || early !== !mon_ev.is_miss || cyc != mon_ev.cyc) begin
          errors++;
          $display("FAIL pulse_match: miss=%0b early=%0b cycle %0d, required miss=%0b early=%0b cycle %0d",
                   miss, early, cyc, mon_ev.is_miss, !mon_ev.is_miss, mon_ev.cyc);
        end
      end
    end
  end

  always @(negedge clk) if (miss_s === 1'b1) s_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive a one-cycle heartbeat 'gap' cycles after the previous one.
  task automatic hb_after(input int gap);
    wait_until(last_drive + gap);
    hb_in = 1'b1;
    last_drive = cyc;
    @(negedge clk);
    hb_in = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d expected pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 7;
    if (st !== 2'd0)             begin errors++; $display("FAIL rst_state: got %0d required 0", st); end
    if (alive !== 1'b0)          begin errors++; $display("FAIL rst_alive: got %0b required 0", alive); end
    if (miss !== 1'b0)           begin errors++; $display("FAIL rst_miss: got %0b required 0", miss); end
    if (early !== 1'b0)          begin errors++; $display("FAIL rst_early: got %0b required 0", early); end
    if (miss_cnt !== 8'd0)       begin errors++; $display("FAIL rst_miss_cnt: got %0d required 0", miss_cnt); end
    if (early_cnt !== 8'd0)      begin errors++; $display("FAIL rst_early_cnt: got %0d required 0", early_cnt); end
    if (last_interval !== 10'd0) begin errors++; $display("FAIL rst_last: got %0d required 0", last_interval); end
    nreset = 1'b1;
    last_drive = cyc;
    // No heartbeat yet: the counter is frozen and no miss may appear.
    wait_until(cyc + 400);
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL idle_hold_state: got %0d required 0", st); end
    check_drained("idle_hold");
  endtask

  task automatic test_lock;
    logic [1:0] exp_st [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    last_drive = cyc;
    for (int i = 0; i < 6; i++) begin
      hb_after(256);
      wait_until(last_drive + 4);
      checks += 2;
      if (st !== exp_st[i]) begin errors++; $display("FAIL lock_state_%0d: got %0d required %0d", i, st, exp_st[i]); end
      if (alive !== (exp_st[i] == 2'd2)) begin errors++; $display("FAIL lock_alive_%0d: got %0b required %0b", i, alive, exp_st[i] == 2'd2); end
    end
    checks++;
    if (last_interval !== 10'd256) begin errors++; $display("FAIL lock_last: got %0d required 256", last_interval); end
    check_drained("lock");
  endtask

  task automatic test_miss;
    exp_q.push_back('{1'b1, last_drive + 262});
    wait_until(last_drive + 262);
    checks += 3;
    if (st !== 2'd3)       begin errors++; $display("FAIL miss_state: got %0d required 3", st); end
    if (alive !== 1'b0)    begin errors++; $display("FAIL miss_alive: got %0b required 0", alive); end
    if (miss_cnt !== 8'd1) begin errors++; $display("FAIL miss_cnt: got %0d required 1", miss_cnt); end
    wait_until(last_drive + 800);
    checks++;
    if (st !== 2'd3) begin errors++; $display("FAIL miss_lost_hold: got %0d required 3", st); end
    check_drained("miss");
  endtask

  task automatic test_boundary_restart;
    int gaps [4] = '{254, 258, 256, 256};
    last_drive = cyc;
    hb_after(300);
    for (int i = 0; i < 4; i++) begin
      hb_after(gaps[i]);
      wait_until(last_drive + 4);
      checks += 2;
      if (last_interval !== 10'(gaps[i])) begin errors++; $display("FAIL bnd_last_%0d: got %0d required %0d", i, last_interval, gaps[i]); end
      if (st !== ((i == 3) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL bnd_state_%0d: got %0d required %0d", i, st, (i == 3) ? 2 : 1); end
    end
    // Stop, let it miss, then a beat landing exactly at HI+1 is restart only.
    exp_q.push_back('{1'b1, last_drive + 262});
    hb_after(259);
    wait_until(last_drive + 3);
    checks += 2;
    if (st !== 2'd3)       begin errors++; $display("FAIL restart_lost: got %0d required 3", st); end
    if (miss_cnt !== 8'd2) begin errors++; $display("FAIL restart_miss_cnt: got %0d required 2", miss_cnt); end
    wait_until(last_drive + 4);
    checks += 2;
    if (st !== 2'd1)              begin errors++; $display("FAIL restart_state: got %0d required 1", st); end
    if (last_interval !== 10'd259) begin errors++; $display("FAIL restart_last: got %0d required 259", last_interval); end
    wait_until(last_drive + 20);
    check_drained("restart");
  endtask

  task automatic test_early;
    hb_after(253);
    exp_q.push_back('{1'b0, last_drive + 4});
    wait_until(last_drive + 4);
    checks += 2;
    if (st !== 2'd1)        begin errors++; $display("FAIL early_acq_state: got %0d required 1", st); end
    if (early_cnt !== 8'd1) begin errors++; $display("FAIL early_acq_cnt: got %0d required 1", early_cnt); end
    repeat (4) hb_after(256);
    wait_until(last_drive + 4);
    checks++;
    if (st !== 2'd2) begin errors++; $display("FAIL early_relock1: got %0d required 2", st); end
    hb_after(250);
    exp_q.push_back('{1'b0, last_drive + 4});
    wait_until(last_drive + 4);
    checks += 3;
    if (st !== 2'd1)        begin errors++; $display("FAIL early_lock_state: got %0d required 1", st); end
    if (alive !== 1'b0)     begin errors++; $display("FAIL early_lock_alive: got %0b required 0", alive); end
    if (early_cnt !== 8'd2) begin errors++; $display("FAIL early_lock_cnt: got %0d required 2", early_cnt); end
    for (int i = 0; i < 4; i++) begin
      hb_after(256);
      wait_until(last_drive + 4);
      checks++;
      if (st !== ((i == 3) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL early_relock_%0d: got %0d required %0d", i, st, (i == 3) ? 2 : 1); end
    end
    check_drained("early");
  endtask

  task automatic test_err_clr;
    exp_q.push_back('{1'b1, last_drive + 262});
    wait_until(last_drive + 261);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    checks += 3;
    if (miss_cnt !== 8'd0)  begin errors++; $display("FAIL clr_miss_cnt: got %0d required 0", miss_cnt); end
    if (early_cnt !== 8'd0) begin errors++; $display("FAIL clr_early_cnt: got %0d required 0", early_cnt); end
    if (st !== 2'd3)        begin errors++; $display("FAIL clr_state: got %0d required 3", st); end
    check_drained("clr");
  endtask

  task automatic test_reset_mid;
    last_drive = cyc;
    hb_after(300);
    repeat (4) hb_after(256);
    hb_after(250);
    exp_q.push_back('{1'b0, last_drive + 4});
    repeat (4) hb_after(256);
    wait_until(last_drive + 20);
    checks += 2;
    if (st !== 2'd2)        begin errors++; $display("FAIL pre_rst_state: got %0d required 2", st); end
    if (early_cnt !== 8'd1) begin errors++; $display("FAIL pre_rst_early_cnt: got %0d required 1", early_cnt); end
    #2 nreset = 1'b0;
    #1;
    checks += 4;
    if (st !== 2'd0)             begin errors++; $display("FAIL mid_rst_state: got %0d required 0", st); end
    if (alive !== 1'b0)          begin errors++; $display("FAIL mid_rst_alive: got %0b required 0", alive); end
    if (early_cnt !== 8'd0)      begin errors++; $display("FAIL mid_rst_early_cnt: got %0d required 0", early_cnt); end
    if (last_interval !== 10'd0) begin errors++; $display("FAIL mid_rst_last: got %0d required 0", last_interval); end
    @(negedge clk);
    nreset = 1'b1;
    wait_until(cyc + 600);
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL post_rst_idle: got %0d required 0", st); end
    check_drained("reset_mid");
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hb_s = 1'b1;
      @(negedge clk);
      hb_s = 1'b0;
      repeat (30) @(negedge clk);
      if (i == 254) begin
        checks++;
        if (miss_cnt_s !== 8'd255) begin errors++; $display("FAIL sat_at_255: got %0d required 255", miss_cnt_s); end
      end
    end
    checks += 2;
    if (s_seen != 300)         begin errors++; $display("FAIL sat_pulses: got %0d required 300", s_seen); end
    if (miss_cnt_s !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d required 255", miss_cnt_s); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_miss();
    test_boundary_restart();
    test_early();
    test_err_clr();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
